// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam int HIGH_SPEED = 150;

    // Pick a pipeline depth from a clock frequency in MHz.
    function automatic int stages_for(input int freq);
        return (freq > HIGH_SPEED) ? 4 : 1;
    endfunction

    // Pass-through bits stored by stage k: completed low result bits, the
    // not-yet-added upper bits of a and b', and the two operand sign bits.
    function automatic int pass_width(input int width, input int stages, input int k);
        int chunk;
        chunk = width / stages;
        return k * chunk + 2 * (width - (k + 1) * chunk) + 2;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry-chain slice of the pipelined adder: slice adder, valid bit,
// load/advance logic and the pass-through registers for this position.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int K      = 0,
    parameter int PASS_W = pass_width(WIDTH, STAGES, K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             ready_next,
    output logic             ready,
    output logic             valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    input  logic [1:0]       sign_in,
    output logic             cout,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out,
    output logic [1:0]       sign_out
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LO    = K * CHUNK;
    localparam int HI    = WIDTH - LO - CHUNK;
    localparam int XW    = 2 * WIDTH + 2;

    logic              valid_q;
    logic              cout_q;
    logic [CHUNK-1:0]  sum_q;
    logic [PASS_W-1:0] pass_q;
    logic [PASS_W-1:0] pass_d;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [CHUNK:0]    slice;
    logic [XW-1:0]     lo_mask;
    logic [XW-1:0]     hi_mask;
    logic [XW-1:0]     pass_w;

    // Empty or draining into the next stage this cycle: !v || (v && next) == !v || next.
    assign ready = !valid_q || ready_next;

    always_comb begin
        a_sh    = a_in >> LO;
        b_sh    = b_in >> LO;
        slice   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};
        lo_mask = (XW'(1) << LO) - XW'(1);
        hi_mask = (XW'(1) << HI) - XW'(1);
        pass_d  = PASS_W'((XW'(res_in) & lo_mask)
                        | (XW'(a_sh >> CHUNK) << LO)
                        | (XW'(b_sh >> CHUNK) << (LO + HI))
                        | (XW'(sign_in) << (LO + 2 * HI)));
        pass_w  = XW'(pass_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
            pass_q  <= '0;
        end else if (ready) begin
            valid_q <= valid_in;
            if (valid_in) begin
                cout_q <= slice[CHUNK];
                sum_q  <= slice[CHUNK-1:0];
                pass_q <= pass_d;
            end
        end
    end

    assign valid    = valid_q;
    assign cout     = cout_q;
    assign res_out  = WIDTH'(pass_w & lo_mask) | (WIDTH'(sum_q) << LO);
    assign a_out    = WIDTH'((pass_w >> LO) & hi_mask) << (LO + CHUNK);
    assign b_out    = WIDTH'((pass_w >> (LO + HI)) & hi_mask) << (LO + CHUNK);
    assign sign_out = pass_w[LO + 2 * HI +: 2];

endmodule

// File: rtl/adder_pipe_param.sv
// Parametrised add/subtract unit with STAGES carry-chain pipeline slices and
// full valid/ready backpressure.
module adder_pipe_param
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             ov
);

    // Handshake: a beat moves on a rising edge where valid && ready on that
    // side; data stays put while valid is high and ready is low.
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] a_c   [STAGES+1];
    logic [WIDTH-1:0] b_c   [STAGES+1];
    logic [WIDTH-1:0] r_c   [STAGES+1];
    logic [1:0]       s_c   [STAGES+1];
    logic             v_c   [STAGES+1];
    logic             cy_c  [STAGES+1];
    logic             rdy_c [STAGES+1];

    assign b_inv        = b ^ {WIDTH{sub_i}};
    assign a_c[0]       = a;
    assign b_c[0]       = b_inv;
    assign r_c[0]       = '0;
    assign s_c[0]       = {a[WIDTH-1], b_inv[WIDTH-1]};
    assign v_c[0]       = valid_i;
    assign cy_c[0]      = sub_i;
    assign rdy_c[STAGES] = ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .K      (k),
            .PASS_W (pass_width(WIDTH, STAGES, k))
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .valid_in   (v_c[k]),
            .ready_next (rdy_c[k+1]),
            .ready      (rdy_c[k]),
            .valid      (v_c[k+1]),
            .cin        (cy_c[k]),
            .a_in       (a_c[k]),
            .b_in       (b_c[k]),
            .res_in     (r_c[k]),
            .sign_in    (s_c[k]),
            .cout       (cy_c[k+1]),
            .a_out      (a_c[k+1]),
            .b_out      (b_c[k+1]),
            .res_out    (r_c[k+1]),
            .sign_out   (s_c[k+1])
        );
    end

    assign ready_o = rdy_c[0] && !rst;
    assign valid_o = v_c[STAGES];
    assign sum     = r_c[STAGES];
    assign c       = cy_c[STAGES];
    // Carry into the MSB is a ^ b' ^ sum at that bit; overflow when it differs from carry out.
    assign ov      = s_c[STAGES][1] ^ s_c[STAGES][0] ^ r_c[STAGES][WIDTH-1] ^ cy_c[STAGES];

endmodule
